// File: rtl/oddr2_tx_pkg.sv
// Shared types and constants for the ODDR2 frame serializer.
// Optional feature macro: ODDR2_TX_PARITY_EN (adds a per-word parity pair).
package oddr2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
`ifdef ODDR2_TX_PARITY_EN
    ST_PARITY   = 3'd3,
`endif
    ST_GAP      = 3'd4
  } state_t;

  localparam int         PAIRS_PER_WORD = 4;
  localparam int         WORD_W         = 8;
  localparam logic [1:0] PREAMBLE_PAIR  = 2'b10;

`ifdef ODDR2_TX_PARITY_EN
  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`endif

endpackage

// File: rtl/oddr2_tx_fifo2.sv
// Two-entry input buffer holding {last, data}; callers never push when full
// or pop when empty.
module oddr2_tx_fifo2 #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  // storage, pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/oddr2_tx_ctrl.sv
// Frame serializer feeding an ODDR2: preamble, MSB-first data pairs, idle gap.
// Optional feature macro: ODDR2_TX_PARITY_EN (one even-parity pair per word).
module oddr2_tx_ctrl
  import oddr2_tx_pkg::*;
#(
  parameter logic IDLE_LEVEL     = 1'b1,
  parameter int   PREAMBLE_PAIRS = 4,
  parameter int   GAP_PAIRS      = 2
) (
  input  logic       C,
  input  logic       R,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  input  logic       IN_LAST,
  output logic       IN_READY,
  output logic       D0,
  output logic       D1,
  output logic       CE,
  output logic       BUSY,
  output logic       UNDERRUN
);

  localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_PAIRS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_PAIRS - 1);
  localparam logic [3:0] WORD_LAST = 4'(PAIRS_PER_WORD - 1);

  state_t       r_state, w_state_nxt, w_end_state;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [7:0]   r_word, w_word_nxt, w_shift;
  logic         r_last, w_last_nxt;
  logic         r_d0, r_d1, r_ce, r_busy, r_underrun, r_rdy_en;
  logic         w_d0, w_d1, w_ce;
  logic         w_push, w_pop, w_end_pop, w_underrun_set, w_end_under;
  logic         w_full, w_empty;
  logic [8:0]   w_fifo_rd;

  assign IN_READY = r_rdy_en & ~w_full;
  assign w_push   = IN_VALID & IN_READY;

  oddr2_tx_fifo2 #(.W(9)) u_fifo (
    .i_clk   (C),
    .i_rst   (R),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({IN_LAST, IN_DATA}),
    .o_data  (w_fifo_rd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // end-of-word decision: close the frame, chain the next word, or starve
  always_comb begin
    w_end_pop   = 1'b0;
    w_end_under = 1'b0;
    if (r_last) begin
      w_end_state = ST_GAP;
    end else if (!w_empty) begin
      w_end_state = ST_DATA;
      w_end_pop   = 1'b1;
    end else begin
      w_end_state = ST_GAP;
      w_end_under = 1'b1;
    end
  end

  // next-state and counter reload on every state entry
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 4'd1;
    w_pop          = 1'b0;
    w_underrun_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (!w_empty) w_state_nxt = ST_PREAMBLE;
        else          w_state_nxt = ST_IDLE;
      end
      ST_PREAMBLE: begin
        if (r_cnt == PRE_LAST) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = 4'd0;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = ST_PREAMBLE;
        end
      end
      ST_DATA: begin
        if (r_cnt == WORD_LAST) begin
`ifdef ODDR2_TX_PARITY_EN
          w_state_nxt    = ST_PARITY;
`else
          w_state_nxt    = w_end_state;
          w_pop          = w_end_pop;
          w_underrun_set = w_end_under;
`endif
          w_cnt_nxt      = 4'd0;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef ODDR2_TX_PARITY_EN
      ST_PARITY: begin
        w_state_nxt    = w_end_state;
        w_pop          = w_end_pop;
        w_underrun_set = w_end_under;
        w_cnt_nxt      = 4'd0;
      end
`endif
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_word_nxt = w_pop ? w_fifo_rd[7:0] : r_word;
  assign w_last_nxt = w_pop ? w_fifo_rd[8]   : r_last;
  // pair k of a word sits in the top two bits after shifting left by 2k
  assign w_shift    = w_word_nxt << {w_cnt_nxt[1:0], 1'b0};

  // line pair for the state being entered, so outputs register with the state
  always_comb begin
    w_d0 = IDLE_LEVEL;
    w_d1 = IDLE_LEVEL;
    w_ce = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_ce = 1'b0;
      end
      ST_PREAMBLE: begin
        {w_d0, w_d1} = PREAMBLE_PAIR;
        w_ce         = 1'b1;
      end
      ST_DATA: begin
        w_d0 = w_shift[7];
        w_d1 = w_shift[6];
        w_ce = 1'b1;
      end
`ifdef ODDR2_TX_PARITY_EN
      ST_PARITY: begin
        w_d0 = even_parity(w_word_nxt);
        w_d1 = ~even_parity(w_word_nxt);
        w_ce = 1'b1;
      end
`endif
      ST_GAP: begin
        w_ce = 1'b1;
      end
      default: begin
        w_ce = 1'b0;
      end
    endcase
  end

  // state, counters and registered line outputs
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_word     <= 8'd0;
      r_last     <= 1'b0;
      r_d0       <= IDLE_LEVEL;
      r_d1       <= IDLE_LEVEL;
      r_ce       <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_word     <= w_word_nxt;
      r_last     <= w_last_nxt;
      r_d0       <= w_d0;
      r_d1       <= w_d1;
      r_ce       <= w_ce;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_underrun <= r_underrun | w_underrun_set;
      r_rdy_en   <= 1'b1;
    end
  end

  assign D0       = r_d0;
  assign D1       = r_d1;
  assign CE       = r_ce;
  assign BUSY     = r_busy;
  assign UNDERRUN = r_underrun;

endmodule

// File: tb/tb_oddr2_tx_ctrl.sv
// Self-checking bench for oddr2_tx_ctrl: a segment-queue model of the line,
// directed frames pinned with literal pair sequences, then random traffic.
module tb_oddr2_tx_ctrl;

  localparam logic IL  = 1'b1;
  localparam int   PRE = 4;
  localparam int   GAP = 2;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic [7:0] IN_DATA = 8'd0;
  logic       IN_VALID = 1'b0;
  logic       IN_LAST = 1'b0;
  logic       IN_READY, D0, D1, CE, BUSY, UNDERRUN;

  int n_chk  = 0;
  int n_pass = 0;

  oddr2_tx_ctrl #(.IDLE_LEVEL(IL), .PREAMBLE_PAIRS(PRE), .GAP_PAIRS(GAP)) dut (
    .C(C), .R(R), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .D0(D0), .D1(D1), .CE(CE), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  always #5 C = ~C;

  // Model: queue of line symbols {ce,d0,d1} still to be shown in the current
  // segment; when it drains, the segment kind decides what comes next.
  logic [2:0] m_sym [$];
  logic [8:0] m_words [$];
  int         m_mode  = 0;        // 0 idle, 1 preamble, 2 word, 3 gap
  logic [2:0] m_out   = {1'b0, IL, IL};
  logic       m_last  = 1'b0;
  logic       m_under = 1'b0;
  logic       m_en    = 1'b0;
  logic [3:0] trace [$];          // {CE,D0,D1,BUSY} per cycle

  task automatic model_reset();
    m_sym.delete();
    m_words.delete();
    m_mode  = 0;
    m_out   = {1'b0, IL, IL};
    m_last  = 1'b0;
    m_under = 1'b0;
    m_en    = 1'b0;
  endtask

  task automatic fill_word(input logic [8:0] w);
    m_last = w[8];
    for (int k = 0; k < 4; k++) m_sym.push_back({1'b1, w[7-2*k], w[6-2*k]});
`ifdef ODDR2_TX_PARITY_EN
    m_sym.push_back({1'b1, ^w[7:0], ~(^w[7:0])});
`endif
    m_mode = 2;
  endtask

  task automatic fill_gap();
    for (int k = 0; k < GAP; k++) m_sym.push_back({1'b1, IL, IL});
    m_mode = 3;
  endtask

  function automatic logic model_ready();
    return m_en && (m_words.size() < 2);
  endfunction

  task automatic model_step();
    logic acc;
    acc = IN_VALID && model_ready();
    if (m_sym.size() > 0) begin
      m_out = m_sym.pop_front();
    end else begin
      case (m_mode)
        0: begin
          if (m_words.size() > 0) begin
            for (int k = 0; k < PRE; k++) m_sym.push_back({1'b1, 1'b1, 1'b0});
            m_mode = 1;
            m_out  = m_sym.pop_front();
          end else begin
            m_out = {1'b0, IL, IL};
          end
        end
        1: begin
          fill_word(m_words.pop_front());
          m_out = m_sym.pop_front();
        end
        2: begin
          if (m_last) begin
            fill_gap();
          end else if (m_words.size() > 0) begin
            fill_word(m_words.pop_front());
          end else begin
            m_under = 1'b1;
            fill_gap();
          end
          m_out = m_sym.pop_front();
        end
        default: begin
          m_mode = 0;
          m_out  = {1'b0, IL, IL};
        end
      endcase
    end
    if (acc) m_words.push_back({IN_LAST, IN_DATA});
    m_en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // one clock: advance the model at the edge, compare everything mid-cycle
  task automatic tick();
    @(posedge C);
    if (R) model_reset();
    else   model_step();
    @(negedge C);
    chk("d0",       64'(D0),       64'(m_out[1]));
    chk("d1",       64'(D1),       64'(m_out[0]));
    chk("ce",       64'(CE),       64'(m_out[2]));
    chk("busy",     64'(BUSY),     64'(m_mode != 0));
    chk("underrun", 64'(UNDERRUN), 64'(m_under));
    chk("in_ready", 64'(IN_READY), 64'(model_ready()));
    trace.push_back({CE, D0, D1, BUSY});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic done;
    done     = 1'b0;
    IN_DATA  = d;
    IN_LAST  = l;
    IN_VALID = 1'b1;
    for (int b = 0; b < 200 && !done; b++) begin
      done = model_ready();
      tick();
    end
    IN_VALID = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
    end
  endtask

  function automatic int busy_cycles();
    int n;
    n = 0;
    foreach (trace[i]) n += int'(trace[i][0]);
    return n;
  endfunction

  // compare the trace from its first CE=1 cycle against literal pairs, then CE=0
  task automatic chk_trace(input string name, input logic [63:0] exp, input int npairs);
    int s;
    s = -1;
    foreach (trace[i]) if (s < 0 && trace[i][3]) s = i;
    if (s < 0 || s + npairs >= trace.size()) begin
      n_chk++;
      $display("FAIL %s: frame of %0d pairs not found in trace", name, npairs);
    end else begin
      for (int k = 0; k < npairs; k++)
        chk(name, 64'(trace[s+k][2:1]), 64'(exp[2*(npairs-1-k) +: 2]));
      chk({name, "_end_ce"}, 64'(trace[s+npairs][3]), 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    R = 1'b1;
    model_reset();
    idle(3);
    chk("rst_d0",       64'(D0),       64'd1);
    chk("rst_d1",       64'(D1),       64'd1);
    chk("rst_ce",       64'(CE),       64'd0);
    chk("rst_ready",    64'(IN_READY), 64'd0);
    chk("rst_busy",     64'(BUSY),     64'd0);
    chk("rst_underrun", 64'(UNDERRUN), 64'd0);
    R = 1'b0;
    tick();
    chk("ready_after_rst", 64'(IN_READY), 64'd1);

`ifndef ODDR2_TX_PARITY_EN
    trace.delete();
    send(8'hA5, 1'b1);
    idle(14);
    chk_trace("a5", 64'b10_10_10_10_10_10_01_01_11_11, 10);
    chk("a5_busy_cycles", 64'(busy_cycles()), 64'd10);

    trace.delete();
    send(8'h3C, 1'b0);
    send(8'hFF, 1'b1);
    idle(20);
    chk_trace("3c_ff", 64'b10_10_10_10_00_11_11_00_11_11_11_11_11_11, 14);
    chk("3c_ff_underrun", 64'(UNDERRUN), 64'd0);

    trace.delete();
    send(8'h12, 1'b0);
    idle(14);
    chk_trace("x12", 64'b10_10_10_10_00_01_00_10_11_11, 10);
    chk("underrun_set", 64'(UNDERRUN), 64'd1);
    send(8'h55, 1'b1);
    idle(14);
    chk("underrun_sticky", 64'(UNDERRUN), 64'd1);

    // reset while the second data pair of 0x81 is on the line
    send(8'h81, 1'b0);
    send(8'h42, 1'b1);
    idle(5);
    chk("mid_ce",   64'(CE),       64'd1);
    chk("mid_pair", 64'({D0, D1}), 64'd0);
    R = 1'b1;
    model_reset();
    #1;
    chk("arst_d0",       64'(D0),       64'd1);
    chk("arst_d1",       64'(D1),       64'd1);
    chk("arst_ce",       64'(CE),       64'd0);
    chk("arst_ready",    64'(IN_READY), 64'd0);
    chk("arst_busy",     64'(BUSY),     64'd0);
    chk("arst_underrun", 64'(UNDERRUN), 64'd0);
    idle(2);
    R = 1'b0;
    trace.delete();
    idle(6);
    chk("fifo_flushed", 64'(busy_cycles()), 64'd0);
    trace.delete();
    send(8'hC3, 1'b1);
    idle(14);
    chk_trace("restart", 64'b10_10_10_10_11_00_00_11_11_11, 10);

    trace.delete();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("fifo_full_ready", 64'(IN_READY), 64'd0);
    send(8'h33, 1'b1);
    idle(25);
    chk_trace("three_words",
              64'b10_10_10_10_00_01_00_01_00_10_00_10_00_11_00_11_11_11, 18);
`else
    trace.delete();
    send(8'h07, 1'b1);
    idle(16);
    chk_trace("parity_07", 64'b10_10_10_10_00_00_01_11_10_11_11, 11);
`endif

    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) begin
        send(8'($urandom), (w == nw - 1) ? ($urandom_range(0, 4) != 0) : 1'b0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 6)));
      end
      if ($urandom_range(0, 9) == 0) begin
        R = 1'b1;
        model_reset();
        idle(2);
        R = 1'b0;
      end
      idle(int'($urandom_range(0, 12)));
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
